// File: rtl/interrupt_config_table_pkg.sv
// rtl/interrupt_config_table_pkg.sv - shared constants, FSM states and entry-config type
package interrupt_config_table_pkg;

  localparam int ICT_ENTRIES = 64;
  localparam int ICT_ENTRY_W = 6;
  localparam int ICT_LEVEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } irq_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   mask;
    logic [ICT_LEVEL_W-1:0] level;
  } ict_conf_t;

endpackage

// File: rtl/interrupt_config_table_if.sv
// rtl/interrupt_config_table_if.sv - config write, interrupt request and offer/ack bundle
interface interrupt_config_table_if;
  import interrupt_config_table_pkg::*;

  logic                   iICT_REQ;
  logic [ICT_ENTRY_W-1:0] iICT_ENTRY;
  logic                   iICT_CONF_MASK;
  logic                   iICT_CONF_VALID;
  logic [ICT_LEVEL_W-1:0] iICT_CONF_LEVEL;
  logic                   iCONF_LOCK;
  logic                   iIRQ_REQ;
  logic [ICT_ENTRY_W-1:0] iIRQ_NUM;
  logic                   iIRQ_ENABLE;
  logic                   oIRQ_VALID;
  logic [ICT_ENTRY_W-1:0] oIRQ_NUM;
  logic [ICT_LEVEL_W-1:0] oIRQ_LEVEL;
  logic                   iIRQ_ACK;
  logic                   oPENDING_ANY;

  modport master (
    output iICT_REQ, iICT_ENTRY, iICT_CONF_MASK, iICT_CONF_VALID, iICT_CONF_LEVEL,
    output iCONF_LOCK, iIRQ_REQ, iIRQ_NUM, iIRQ_ENABLE, iIRQ_ACK,
    input  oIRQ_VALID, oIRQ_NUM, oIRQ_LEVEL, oPENDING_ANY
  );

  modport slave (
    input  iICT_REQ, iICT_ENTRY, iICT_CONF_MASK, iICT_CONF_VALID, iICT_CONF_LEVEL,
    input  iCONF_LOCK, iIRQ_REQ, iIRQ_NUM, iIRQ_ENABLE, iIRQ_ACK,
    output oIRQ_VALID, oIRQ_NUM, oIRQ_LEVEL, oPENDING_ANY
  );

endinterface

// File: rtl/interrupt_config_table_irq_priority_select.sv
// rtl/interrupt_config_table_irq_priority_select.sv - 64-way highest-level, lowest-index picker
module irq_priority_select
  import interrupt_config_table_pkg::*;
(
  input  logic [ICT_ENTRIES-1:0]                  dispatch_i,
  input  logic [ICT_ENTRIES-1:0][ICT_LEVEL_W-1:0] levels_i,
  output logic                                    found_o,
  output logic [ICT_ENTRY_W-1:0]                  num_o,
  output logic [ICT_LEVEL_W-1:0]                  level_o
);

  // Scan from the top index down; ">=" lets a lower index take over on equal level.
  always_comb begin
    found_o = 1'b0;
    num_o   = '0;
    level_o = '0;
    for (int i = ICT_ENTRIES - 1; i >= 0; i--) begin
      if (dispatch_i[i] && (!found_o || levels_i[i] >= level_o)) begin
        found_o = 1'b1;
        num_o   = ICT_ENTRY_W'(i);
        level_o = levels_i[i];
      end
    end
  end

endmodule

// File: rtl/interrupt_config_table.sv
// rtl/interrupt_config_table.sv - interrupt config storage, pending latch and offer/ack FSM
module interrupt_config_table
  import interrupt_config_table_pkg::*;
(
  input logic                     iCLOCK,
  input logic                     inRESET,
  interrupt_config_table_if.slave bus
);

  ict_conf_t                             conf_q [ICT_ENTRIES];
  ict_conf_t                             wr_conf;
  logic [ICT_ENTRIES-1:0]                pending_q, pending_d;
  irq_state_e                            state_q, state_d;
  logic [ICT_ENTRY_W-1:0]                num_q, num_d;
  logic [ICT_LEVEL_W-1:0]                level_q, level_d;
  logic [ICT_ENTRIES-1:0]                dispatch;
  logic [ICT_ENTRIES-1:0][ICT_LEVEL_W-1:0] levels;
  logic                                  sel_found;
  logic [ICT_ENTRY_W-1:0]                sel_num;
  logic [ICT_LEVEL_W-1:0]                sel_level;
  logic                                  offering;

  assign offering = (state_q == ST_OFFER);
  assign wr_conf  = '{valid: bus.iICT_CONF_VALID, mask: bus.iICT_CONF_MASK,
                      level: bus.iICT_CONF_LEVEL};

  // Configuration table: one entry overwritten per write strobe.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      for (int i = 0; i < ICT_ENTRIES; i++) conf_q[i] <= '0;
    end else if (bus.iICT_REQ) begin
      conf_q[bus.iICT_ENTRY] <= wr_conf;
    end
  end

  // Pending update: invalidate-clear and ack-clear first, request-set last so set wins.
  always_comb begin
    pending_d = pending_q;
    if (bus.iICT_REQ && !bus.iICT_CONF_VALID && !(offering && bus.iICT_ENTRY == num_q))
      pending_d[bus.iICT_ENTRY] = 1'b0;
    if (offering && bus.iIRQ_ACK)
      pending_d[num_q] = 1'b0;
    if (bus.iIRQ_REQ && conf_q[bus.iIRQ_NUM].valid)
      pending_d[bus.iIRQ_NUM] = 1'b1;
  end

  // Pending register.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  // Dispatchable vector and level view fed to the picker, from registered state only.
  always_comb begin
    for (int i = 0; i < ICT_ENTRIES; i++) begin
      dispatch[i] = pending_q[i] & conf_q[i].valid & ~conf_q[i].mask;
      levels[i]   = conf_q[i].level;
    end
  end

  irq_priority_select u_select (
    .dispatch_i (dispatch),
    .levels_i   (levels),
    .found_o    (sel_found),
    .num_o      (sel_num),
    .level_o    (sel_level)
  );

  // FSM state register with the captured offer.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      level_q <= level_d;
    end
  end

  // FSM next state: capture a winner in IDLE, hold it until acknowledged.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    level_d = level_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iIRQ_ENABLE && !bus.iCONF_LOCK && sel_found) begin
          state_d = ST_OFFER;
          num_d   = sel_num;
          level_d = sel_level;
        end
      end
      ST_OFFER: begin
        if (bus.iIRQ_ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: offer driven straight from registers, pending summary from pending bits.
  always_comb begin
    bus.oIRQ_VALID   = offering;
    bus.oIRQ_NUM     = num_q;
    bus.oIRQ_LEVEL   = level_q;
    bus.oPENDING_ANY = |pending_q;
  end

endmodule

// File: tb/tb_interrupt_config_table.sv
// tb/tb_interrupt_config_table.sv - scoreboard bench with reference model for interrupt_config_table
module tb_interrupt_config_table;

  logic clk;
  logic rstn;

  interrupt_config_table_if bus();

  interrupt_config_table dut (
    .iCLOCK  (clk),
    .inRESET (rstn),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         full;
    bit         v;
    logic [5:0] n;
    logic [1:0] l;
    bit         pa;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: the table as plain arrays plus the current offer.
  bit m_valid [64];
  bit m_mask  [64];
  int m_level [64];
  bit m_pend  [64];
  bit m_offer;
  int m_onum;
  int m_olevel;

  function automatic bit pick(output int n, output int l);
    for (int lv = 3; lv >= 0; lv--)
      for (int i = 0; i < 64; i++)
        if (m_pend[i] && m_valid[i] && !m_mask[i] && m_level[i] == lv) begin
          n = i;
          l = lv;
          return 1'b1;
        end
    n = 0;
    l = 0;
    return 1'b0;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < 64; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_edge();
    bit np [64];
    int n, l;
    int we, rn;
    if (!rstn) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 0; m_mask[i] = 0; m_level[i] = 0; m_pend[i] = 0;
      end
      m_offer = 0; m_onum = 0; m_olevel = 0;
      return;
    end
    we = int'(bus.iICT_ENTRY);
    rn = int'(bus.iIRQ_NUM);
    np = m_pend;
    if (bus.iICT_REQ && !bus.iICT_CONF_VALID && !(m_offer && we == m_onum)) np[we] = 0;
    if (m_offer && bus.iIRQ_ACK) np[m_onum] = 0;
    if (bus.iIRQ_REQ && m_valid[rn]) np[rn] = 1;
    if (!m_offer) begin
      if (bus.iIRQ_ENABLE && !bus.iCONF_LOCK && pick(n, l)) begin
        m_offer = 1; m_onum = n; m_olevel = l;
      end
    end else if (bus.iIRQ_ACK) begin
      m_offer = 0;
    end
    if (bus.iICT_REQ) begin
      m_valid[we] = bus.iICT_CONF_VALID;
      m_mask[we]  = bus.iICT_CONF_MASK;
      m_level[we] = int'(bus.iICT_CONF_LEVEL);
    end
    m_pend = np;
  endfunction

  // One clock: update the model with the driven inputs, queue the post-edge expectation.
  task automatic tick();
    exp_t e;
    e.full = !rstn;
    model_edge();
    e.v  = m_offer;
    e.n  = 6'(m_onum);
    e.l  = 2'(m_olevel);
    e.pa = any_pending();
    exp_q.push_back(e);
    @(negedge clk);
    bus.iICT_REQ = 1'b0;
    bus.iIRQ_REQ = 1'b0;
    bus.iIRQ_ACK = 1'b0;
  endtask

  task automatic cfg(input int entry, input bit v, input bit m, input int lv);
    bus.iICT_REQ        = 1'b1;
    bus.iICT_ENTRY      = 6'(entry);
    bus.iICT_CONF_VALID = v;
    bus.iICT_CONF_MASK  = m;
    bus.iICT_CONF_LEVEL = 2'(lv);
    tick();
  endtask

  task automatic req(input int num);
    bus.iIRQ_REQ = 1'b1;
    bus.iIRQ_NUM = 6'(num);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ack_offer();
    for (int i = 0; i < 20; i++) begin
      if (m_offer) begin
        bus.iIRQ_ACK = 1'b1;
        tick();
        return;
      end
      tick();
    end
  endtask

  // Monitor: compares every registered output set shortly after each active edge.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (bus.oIRQ_VALID === e.v) && (bus.oPENDING_ANY === e.pa);
        if (e.v || e.full) ok = ok && (bus.oIRQ_NUM === e.n) && (bus.oIRQ_LEVEL === e.l);
        checks++;
        if (ok) passed++;
        else
          $display("FAIL offer t=%0t got valid=%0b num=%0d level=%0d pend_any=%0b want valid=%0b num=%0d level=%0d pend_any=%0b",
                   $time, bus.oIRQ_VALID, bus.oIRQ_NUM, bus.oIRQ_LEVEL, bus.oPENDING_ANY,
                   e.v, e.n, e.l, e.pa);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got still-running want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn                = 1'b0;
    bus.iICT_REQ        = 1'b0;
    bus.iICT_ENTRY      = '0;
    bus.iICT_CONF_MASK  = 1'b0;
    bus.iICT_CONF_VALID = 1'b0;
    bus.iICT_CONF_LEVEL = '0;
    bus.iCONF_LOCK      = 1'b0;
    bus.iIRQ_REQ        = 1'b0;
    bus.iIRQ_NUM        = '0;
    bus.iIRQ_ENABLE     = 1'b1;
    bus.iIRQ_ACK        = 1'b0;
    @(negedge clk);
    idle(2);
    rstn = 1'b1;

    // Whole table valid, unmasked, level 0; 5 then 9 requested back to back.
    for (int i = 0; i < 64; i++) cfg(i, 1, 0, 0);
    req(5);
    req(9);
    ack_offer();
    ack_offer();
    idle(2);

    // Levels: 40 at level 3 beats 12 at level 1 when both pending at once.
    cfg(12, 1, 0, 1);
    cfg(40, 1, 0, 3);
    bus.iIRQ_ENABLE = 1'b0;
    req(12);
    req(40);
    bus.iIRQ_ENABLE = 1'b1;
    ack_offer();
    ack_offer();
    idle(2);

    // Masked entry latches but is not offered until unmasked.
    cfg(7, 1, 1, 0);
    req(7);
    idle(3);
    cfg(7, 1, 0, 0);
    ack_offer();
    idle(2);

    // Invalid entry drops the request; disabled interrupts hold the offer back.
    cfg(20, 0, 0, 0);
    req(20);
    idle(3);
    bus.iIRQ_ENABLE = 1'b0;
    req(3);
    idle(3);
    bus.iIRQ_ENABLE = 1'b1;
    idle(2);

    // During the offer of 3: invalidate, restore, lock pulse, then ack with a fresh request.
    cfg(3, 0, 0, 0);
    cfg(3, 1, 0, 2);
    bus.iCONF_LOCK = 1'b1;
    idle(2);
    bus.iIRQ_ACK = 1'b1;
    bus.iIRQ_REQ = 1'b1;
    bus.iIRQ_NUM = 6'd3;
    tick();
    idle(2);
    bus.iCONF_LOCK = 1'b0;
    ack_offer();
    idle(2);

    // Reset in the middle of an offer, then a stray ack.
    cfg(33, 1, 0, 2);
    req(33);
    idle(2);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.iIRQ_ACK = 1'b1;
    tick();
    idle(2);

    // Randomised traffic concentrated on a few entries to provoke collisions.
    for (int c = 0; c < 2500; c++) begin
      rstn                = ($urandom_range(0, 299) != 0);
      bus.iICT_REQ        = ($urandom_range(0, 2) == 0);
      bus.iICT_ENTRY      = 6'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 7));
      bus.iICT_CONF_VALID = ($urandom_range(0, 3) != 0);
      bus.iICT_CONF_MASK  = ($urandom_range(0, 3) == 0);
      bus.iICT_CONF_LEVEL = 2'($urandom_range(0, 3));
      bus.iCONF_LOCK      = ($urandom_range(0, 7) == 0);
      bus.iIRQ_REQ        = ($urandom_range(0, 1) == 0);
      bus.iIRQ_NUM        = 6'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 7));
      bus.iIRQ_ENABLE     = ($urandom_range(0, 7) != 0);
      bus.iIRQ_ACK        = m_offer ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      tick();
    end
    rstn = 1'b1;
    bus.iCONF_LOCK  = 1'b0;
    bus.iIRQ_ENABLE = 1'b1;
    idle(3);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got %0d leftover want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
